// File: rtl/icache_fetch_if.sv
// Fetch-side and backing-memory signals of the instruction cache.
// The cache takes the slave view; the fetch stage and memory take the master view.
interface icache_fetch_if #(
  parameter int CNT_W = 16
);
  logic             req_i;
  logic [31:0]      addr_i;
  logic             flush_i;
  logic [31:0]      instr_o;
  logic             stall_o;
  logic             mem_req_o;
  logic [31:0]      mem_addr_o;
  logic             mem_ack_i;
  logic [31:0]      mem_data_i;
  logic [CNT_W-1:0] miss_cnt_o;

  modport slave (
    input  req_i, addr_i, flush_i,
    input  mem_ack_i, mem_data_i,
    output instr_o, stall_o,
    output mem_req_o, mem_addr_o,
    output miss_cnt_o
  );

  modport master (
    output req_i, addr_i, flush_i,
    output mem_ack_i, mem_data_i,
    input  instr_o, stall_o,
    input  mem_req_o, mem_addr_o,
    input  miss_cnt_o
  );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with
// whole-line in-order refill from a handshaked memory.
module icache_fetch #(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int CNT_W = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  icache_fetch_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  logic [TAG_W-1:0] ltag_q;
  logic [IDX_W-1:0] lidx_q;
  logic [OFF_W-1:0] cnt_q;
  logic [CNT_W-1:0] miss_q;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             start;
  logic             fill;
  logic             last;
  logic             unused_lsb;

  assign off = bus.addr_i[OFF_W+1:2];
  assign idx = bus.addr_i[IDX_W+OFF_W+1:OFF_W+2];
  assign tag = bus.addr_i[31:IDX_W+OFF_W+2];
  assign unused_lsb = ^bus.addr_i[1:0];

  assign hit = bus.req_i & valid_q[idx]
             & (tag_q[idx] == tag)
             & (state_q == IDLE);

  // Next-state: start refill on a miss, finish on the last ack, abort on flush
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    fill    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_i & ~hit & ~bus.flush_i) begin
          state_d = REFILL;
          start   = 1'b1;
        end
      end
      REFILL: begin
        fill = bus.mem_ack_i;
        if (bus.flush_i) begin
          state_d = IDLE;
        end else if (bus.mem_ack_i &&
                     cnt_q == OFF_W'(WORDS-1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch-side and memory-side outputs
  always_comb begin
    bus.instr_o    = hit ? data_q[idx][off] : 32'h0;
    bus.stall_o    = bus.req_i & ~hit;
    bus.mem_req_o  = (state_q == REFILL);
    bus.mem_addr_o = '0;
    if (state_q == REFILL)
      bus.mem_addr_o = {ltag_q, lidx_q, cnt_q, 2'b00};
    bus.miss_cnt_o = miss_q;
  end

  // Control state, valid bits and saturating miss counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      ltag_q  <= '0;
      lidx_q  <= '0;
      cnt_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        ltag_q <= tag;
        lidx_q <= idx;
        cnt_q  <= '0;
        if (~&miss_q)
          miss_q <= miss_q + 1'b1;
      end else if (fill) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (bus.flush_i)
        valid_q <= '0;
      else if (last)
        valid_q[lidx_q] <= 1'b1;
    end
  end

  // Line data and tags; contents are meaningless until validated
  always_ff @(posedge clk_i) begin
    if (fill)
      data_q[lidx_q][cnt_q] <= bus.mem_data_i;
    if (last)
      tag_q[lidx_q] <= ltag_q;
  end
endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: directed scenarios then random traffic,
// checked against a line-level cache model through a scoreboard.
module tb_icache_fetch;
  logic clk;
  logic rst;

  icache_fetch_if #(.CNT_W(4)) bus ();

  icache_fetch #(
    .LINES(16),
    .WORDS(4),
    .CNT_W(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        stall;
    logic        mreq;
    logic [31:0] maddr;
    logic [3:0]  mc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  bit          mv [16];
  logic [23:0] mt [16];
  bit          mref;
  logic [31:0] mbase;
  int          mk;
  int          mmiss;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return ((a ^ 32'h5A5A_C3C3) * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  task automatic mclear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  task automatic mreset();
    mclear();
    mref  = 1'b0;
    mk    = 0;
    mmiss = 0;
  endtask

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               n, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the expected outputs go to the scoreboard
  task automatic step(input bit rq, input logic [31:0] a,
                      input bit fl, input bit ak, input bit rs);
    exp_t        e;
    int          idx;
    bit          hit;
    logic [31:0] ma;
    @(posedge clk);
    #1;
    if (rs) begin
      rst = 1'b1;
      mreset();
    end else begin
      rst = 1'b0;
    end
    ma = mref ? mbase + 32'(mk * 4) : 32'h0;
    bus.req_i      = rq;
    bus.addr_i     = a;
    bus.flush_i    = fl;
    bus.mem_ack_i  = ak;
    bus.mem_data_i = ak ? mw(ma) : $urandom;
    idx = int'(a[7:4]);
    hit = rq && !mref && mv[idx] && mt[idx] == a[31:8];
    e.instr = hit ? mw({a[31:2], 2'b00}) : 32'h0;
    e.stall = rq && !hit;
    e.mreq  = mref;
    e.maddr = ma;
    e.mc    = 4'(mmiss);
    sb.push_back(e);
    if (!rs) begin
      if (!mref) begin
        if (fl) mclear();
        else if (rq && !hit) begin
          mref  = 1'b1;
          mbase = {a[31:4], 4'b0000};
          mk    = 0;
          if (mmiss < 15) mmiss++;
        end
      end else if (fl) begin
        mclear();
        mref = 1'b0;
      end else if (ak) begin
        if (mk == 3) begin
          mv[mbase[7:4]] = 1'b1;
          mt[mbase[7:4]] = mbase[31:8];
          mref = 1'b0;
        end
        mk++;
      end
    end
  endtask

  task automatic fill(input logic [31:0] a, input int dly);
    step(1, a, 0, 0, 0);
    for (int w = 0; w < 4; w++) begin
      for (int d = 0; d < dly; d++) step(1, a, 0, 0, 0);
      step(1, a, 0, 1, 0);
    end
  endtask

  // Monitor: compare each presented cycle against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("instr", bus.instr_o, e.instr);
      chk("stall", 32'(bus.stall_o), 32'(e.stall));
      chk("mem_req", 32'(bus.mem_req_o), 32'(e.mreq));
      chk("mem_addr", bus.mem_addr_o, e.maddr);
      chk("miss_cnt", 32'(bus.miss_cnt_o), 32'(e.mc));
    end
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    bus.req_i = 0;
    bus.addr_i = 0;
    bus.flush_i = 0;
    bus.mem_ack_i = 0;
    bus.mem_data_i = 0;
    mreset();
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    // cold miss, then hits on the same line
    fill(32'h0, 0);
    step(1, 32'h0, 0, 0, 0);
    step(1, 32'h8, 0, 0, 0);
    // conflict on index 0
    fill(32'h100, 0);
    step(1, 32'h104, 0, 0, 0);
    fill(32'h0, 0);
    step(1, 32'hC, 0, 0, 0);
    // slow memory, ack three cycles after each request
    fill(32'h40, 2);
    for (int i = 0; i < 4; i++) step(1, 32'h40 + 32'(4*i), 0, 0, 0);
    // flush after two acks, then re-request
    step(1, 32'h80, 0, 0, 0);
    step(1, 32'h80, 0, 1, 0);
    step(1, 32'h80, 0, 1, 0);
    step(0, 32'h80, 1, 0, 0);
    step(0, 32'h80, 0, 0, 0);
    fill(32'h80, 0);
    step(1, 32'h84, 0, 0, 0);
    step(1, 32'h40, 0, 0, 0);
    fill(32'h0, 1);
    step(1, 32'h4, 0, 0, 0);
    // async reset mid-refill; previously valid line misses after
    step(1, 32'hC0, 0, 0, 0);
    step(1, 32'hC0, 0, 1, 0);
    step(1, 32'hC0, 0, 0, 1);
    fill(32'h0, 0);
    step(1, 32'h0, 0, 0, 0);
    // miss counter saturation
    for (int i = 0; i < 20; i++) fill(32'(i) << 8, 0);
    step(1, 32'h1300, 0, 0, 0);
    // random traffic, ack in IDLE included
    for (int i = 0; i < 3000; i++) begin
      a = $urandom & 32'h0000_03FF;
      if ($urandom_range(0, 3) == 0) a = a | 32'hF000_0000;
      step($urandom_range(0, 4) != 0, a,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 499) == 0);
    end
    step(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
